// File: rtl/axi4lite_arbiter_2m.sv
// Two-master to one-slave AXI4-Lite arbiter, independent round-robin write and read paths, one outstanding each.
// Grant is registered (1 cycle from request to s_*valid); slave backpressure passes straight to the granted master only.
module axi4lite_arbiter_2m #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   m0_awaddr,
    input  logic [2:0]              m0_awprot,
    input  logic                    m0_awvalid,
    output logic                    m0_awready,
    input  logic [DATA_WIDTH-1:0]   m0_wdata,
    input  logic [DATA_WIDTH/8-1:0] m0_wstrb,
    input  logic                    m0_wvalid,
    output logic                    m0_wready,
    output logic [1:0]              m0_bresp,
    output logic                    m0_bvalid,
    input  logic                    m0_bready,
    input  logic [ADDR_WIDTH-1:0]   m0_araddr,
    input  logic [2:0]              m0_arprot,
    input  logic                    m0_arvalid,
    output logic                    m0_arready,
    output logic [DATA_WIDTH-1:0]   m0_rdata,
    output logic [1:0]              m0_rresp,
    output logic                    m0_rvalid,
    input  logic                    m0_rready,
    input  logic [ADDR_WIDTH-1:0]   m1_awaddr,
    input  logic [2:0]              m1_awprot,
    input  logic                    m1_awvalid,
    output logic                    m1_awready,
    input  logic [DATA_WIDTH-1:0]   m1_wdata,
    input  logic [DATA_WIDTH/8-1:0] m1_wstrb,
    input  logic                    m1_wvalid,
    output logic                    m1_wready,
    output logic [1:0]              m1_bresp,
    output logic                    m1_bvalid,
    input  logic                    m1_bready,
    input  logic [ADDR_WIDTH-1:0]   m1_araddr,
    input  logic [2:0]              m1_arprot,
    input  logic                    m1_arvalid,
    output logic                    m1_arready,
    output logic [DATA_WIDTH-1:0]   m1_rdata,
    output logic [1:0]              m1_rresp,
    output logic                    m1_rvalid,
    input  logic                    m1_rready,
    output logic [ADDR_WIDTH-1:0]   s_awaddr,
    output logic [2:0]              s_awprot,
    output logic                    s_awvalid,
    input  logic                    s_awready,
    output logic [DATA_WIDTH-1:0]   s_wdata,
    output logic [DATA_WIDTH/8-1:0] s_wstrb,
    output logic                    s_wvalid,
    input  logic                    s_wready,
    input  logic [1:0]              s_bresp,
    input  logic                    s_bvalid,
    output logic                    s_bready,
    output logic [ADDR_WIDTH-1:0]   s_araddr,
    output logic [2:0]              s_arprot,
    output logic                    s_arvalid,
    input  logic                    s_arready,
    input  logic [DATA_WIDTH-1:0]   s_rdata,
    input  logic [1:0]              s_rresp,
    input  logic                    s_rvalid,
    output logic                    s_rready,
    output logic [1:0]              wr_gnt,
    output logic [1:0]              rd_gnt
);

    typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} wst_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rst_t;

    wst_t r_wst, w_wst_nxt;
    rst_t r_rst, w_rst_nxt;
    logic r_wgnt, r_wlast, r_aw_done, r_w_done;
    logic r_rgnt, r_rlast;

    logic w_wreq0, w_wreq1, w_wpick, w_wsel;
    logic w_aw_hs, w_w_hs, w_b_hs, w_wxfer_fin;
    logic w_rpick, w_rsel, w_ar_hs, w_r_hs;
    logic w_m_awvalid, w_m_wvalid, w_m_bready, w_m_arvalid, w_m_rready;

    // Round-robin: on a tie the master that did not win last goes; r_*last resets to 1 so m0 wins first.
    assign w_wreq0     = m0_awvalid | m0_wvalid;
    assign w_wreq1     = m1_awvalid | m1_wvalid;
    assign w_wpick     = (w_wreq0 & w_wreq1) ? ~r_wlast : w_wreq1;
    assign w_rpick     = (m0_arvalid & m1_arvalid) ? ~r_rlast : m1_arvalid;
    assign w_wsel      = (r_wst != W_IDLE) & r_wgnt;
    assign w_rsel      = (r_rst != R_IDLE) & r_rgnt;

    assign w_aw_hs     = s_awvalid & s_awready;
    assign w_w_hs      = s_wvalid & s_wready;
    assign w_b_hs      = s_bvalid & s_bready;
    assign w_ar_hs     = s_arvalid & s_arready;
    assign w_r_hs      = s_rvalid & s_rready;
    assign w_wxfer_fin = (r_wst == W_XFER) & (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);

    assign w_m_awvalid = w_wsel ? m1_awvalid : m0_awvalid;
    assign w_m_wvalid  = w_wsel ? m1_wvalid  : m0_wvalid;
    assign w_m_bready  = w_wsel ? m1_bready  : m0_bready;
    assign w_m_arvalid = w_rsel ? m1_arvalid : m0_arvalid;
    assign w_m_rready  = w_rsel ? m1_rready  : m0_rready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wst <= W_IDLE;
            r_rst <= R_IDLE;
        end else begin
            r_wst <= w_wst_nxt;
            r_rst <= w_rst_nxt;
        end
    end

    always_comb begin
        w_wst_nxt = r_wst;
        case (r_wst)
            W_IDLE:  if (w_wreq0 | w_wreq1) w_wst_nxt = W_XFER;
            W_XFER:  if (w_wxfer_fin)       w_wst_nxt = W_RESP;
            W_RESP:  if (w_b_hs)            w_wst_nxt = W_IDLE;
            default:                        w_wst_nxt = W_IDLE;
        endcase
        w_rst_nxt = r_rst;
        case (r_rst)
            R_IDLE:  if (m0_arvalid | m1_arvalid) w_rst_nxt = R_ADDR;
            R_ADDR:  if (w_ar_hs)                 w_rst_nxt = R_DATA;
            R_DATA:  if (w_r_hs)                  w_rst_nxt = R_IDLE;
            default:                              w_rst_nxt = R_IDLE;
        endcase
    end

    // Grant, done flags and last-winner pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wgnt    <= 1'b0;
            r_wlast   <= 1'b1;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_rgnt    <= 1'b0;
            r_rlast   <= 1'b1;
        end else begin
            if (r_wst == W_IDLE && (w_wreq0 | w_wreq1)) r_wgnt <= w_wpick;
            if (w_wxfer_fin) begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end else begin
                if (w_aw_hs) r_aw_done <= 1'b1;
                if (w_w_hs)  r_w_done  <= 1'b1;
            end
            if (w_b_hs) r_wlast <= r_wgnt;
            if (r_rst == R_IDLE && (m0_arvalid | m1_arvalid)) r_rgnt <= w_rpick;
            if (w_r_hs) r_rlast <= r_rgnt;
        end
    end

    always_comb begin
        s_awaddr   = w_wsel ? m1_awaddr : m0_awaddr;
        s_awprot   = w_wsel ? m1_awprot : m0_awprot;
        s_wdata    = w_wsel ? m1_wdata  : m0_wdata;
        s_wstrb    = w_wsel ? m1_wstrb  : m0_wstrb;
        s_awvalid  = 1'b0;
        s_wvalid   = 1'b0;
        s_bready   = 1'b0;
        m0_awready = 1'b0;
        m1_awready = 1'b0;
        m0_wready  = 1'b0;
        m1_wready  = 1'b0;
        m0_bvalid  = 1'b0;
        m1_bvalid  = 1'b0;
        m0_bresp   = 2'b00;
        m1_bresp   = 2'b00;
        wr_gnt     = 2'b00;
        case (r_wst)
            W_XFER: begin
                s_awvalid = w_m_awvalid & ~r_aw_done;
                s_wvalid  = w_m_wvalid & ~r_w_done;
                if (r_wgnt) begin
                    m1_awready = s_awready & ~r_aw_done;
                    m1_wready  = s_wready & ~r_w_done;
                end else begin
                    m0_awready = s_awready & ~r_aw_done;
                    m0_wready  = s_wready & ~r_w_done;
                end
            end
            W_RESP: begin
                s_bready = w_m_bready;
                if (r_wgnt) begin
                    m1_bvalid = s_bvalid;
                    m1_bresp  = s_bresp;
                end else begin
                    m0_bvalid = s_bvalid;
                    m0_bresp  = s_bresp;
                end
            end
            default: ;
        endcase
        if (r_wst != W_IDLE) wr_gnt = r_wgnt ? 2'b10 : 2'b01;
    end

    always_comb begin
        s_araddr   = w_rsel ? m1_araddr : m0_araddr;
        s_arprot   = w_rsel ? m1_arprot : m0_arprot;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        m0_rvalid  = 1'b0;
        m1_rvalid  = 1'b0;
        m0_rdata   = '0;
        m1_rdata   = '0;
        m0_rresp   = 2'b00;
        m1_rresp   = 2'b00;
        rd_gnt     = 2'b00;
        case (r_rst)
            R_ADDR: begin
                s_arvalid = w_m_arvalid;
                if (r_rgnt) m1_arready = s_arready;
                else        m0_arready = s_arready;
            end
            R_DATA: begin
                s_rready = w_m_rready;
                if (r_rgnt) begin
                    m1_rvalid = s_rvalid;
                    m1_rdata  = s_rdata;
                    m1_rresp  = s_rresp;
                end else begin
                    m0_rvalid = s_rvalid;
                    m0_rdata  = s_rdata;
                    m0_rresp  = s_rresp;
                end
            end
            default: ;
        endcase
        if (r_rst != R_IDLE) rd_gnt = r_rgnt ? 2'b10 : 2'b01;
    end

endmodule
